// File: rtl/msrv32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msrv32_pkg: shared types and constants for the data-memory bus     |
// | controller.                                       Revision: 1.0    |
// +--------------------------------------------------------------------+
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } dmem_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/msrv32_wr_lane_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msrv32_wr_lane_gen: size/offset decode into byte mask, replicated  |
// | write data and misalignment flag.                 Revision: 1.0    |
// +--------------------------------------------------------------------+
module msrv32_wr_lane_gen
  import msrv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [3:0]  mask,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    mask       = 4'b1111;
    lane_data  = rs2;
    misaligned = |offset;
    case (funct3)
      FUNCT3_LB, FUNCT3_LBU: begin
        mask       = 4'b0001 << offset;
        lane_data  = {4{rs2[7:0]}};
        misaligned = 1'b0;
      end
      FUNCT3_LH, FUNCT3_LHU: begin
        mask       = offset[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{rs2[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        // word and any unlisted encoding behave as a full-word access
        mask       = 4'b1111;
        lane_data  = rs2;
        misaligned = |offset;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/msrv32_dmem_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msrv32_dmem_bus_ctrl: single-outstanding AHB-style data-memory     |
// | master. Define MSRV32_DMEM_TIMEOUT_EN for per-phase wait abort.    |
// |                                                   Revision: 1.0    |
// +--------------------------------------------------------------------+
module msrv32_dmem_bus_ctrl
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic [1:0]  load_offset_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  wire clk = ms_riscv32_mp_clk_in;
  wire rst = ms_riscv32_mp_rst_in;

  dmem_state_e r_state;
  dmem_state_e w_state_next;

  logic [3:0]  w_mask;
  logic [31:0] w_lane_data;
  logic        w_misaligned;
  logic        w_req;
  logic        w_accept;
  logic        w_timeout;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_wr;
  logic [1:0]  r_offset;
  logic [31:0] r_load_data;
  logic [1:0]  r_load_offset;
  logic        r_load_valid;
  logic        r_misaligned;
  logic        r_bus_err;

  msrv32_wr_lane_gen u_lane_gen (
    .funct3     (funct3_in),
    .offset     (iadder_in[1:0]),
    .rs2        (rs2_in),
    .mask       (w_mask),
    .lane_data  (w_lane_data),
    .misaligned (w_misaligned)
  );

  assign w_req    = mem_rd_req_in | mem_wr_req_in;
  assign w_accept = (r_state == ST_IDLE) && w_req && !w_misaligned;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // counts consecutive not-ready cycles within the current phase only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_IDLE) || (w_state_next != r_state)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && !ahb_ready_in &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_ADDR;
      ST_ADDR: begin
        if (ahb_ready_in)   w_state_next = ST_DATA;
        else if (w_timeout) w_state_next = ST_IDLE;
      end
      ST_DATA: if (ahb_ready_in || w_timeout) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    ahb_htrans_out              = HTRANS_IDLE;
    stall_out                   = 1'b0;
    ms_riscv32_mp_dmaddr_out    = '0;
    ms_riscv32_mp_dmdata_out    = '0;
    ms_riscv32_mp_dmwr_mask_out = '0;
    ms_riscv32_mp_dmwr_req_out  = 1'b0;
    case (r_state)
      ST_IDLE: stall_out = w_accept;
      ST_ADDR: begin
        ahb_htrans_out = HTRANS_NONSEQ;
        stall_out      = 1'b1;
      end
      ST_DATA: stall_out = !ahb_ready_in && !w_timeout;
      default: stall_out = 1'b0;
    endcase
    if (r_state != ST_IDLE) begin
      ms_riscv32_mp_dmaddr_out    = r_addr;
      ms_riscv32_mp_dmdata_out    = r_wdata;
      ms_riscv32_mp_dmwr_mask_out = r_mask;
      ms_riscv32_mp_dmwr_req_out  = r_wr;
    end
  end

  // request capture, load capture and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_mask        <= '0;
      r_wr          <= 1'b0;
      r_offset      <= '0;
      r_load_data   <= '0;
      r_load_offset <= '0;
      r_load_valid  <= 1'b0;
      r_misaligned  <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= {iadder_in[31:2], 2'b00};
        r_wdata  <= mem_wr_req_in ? w_lane_data : 32'd0;
        r_mask   <= mem_wr_req_in ? w_mask : 4'd0;
        r_wr     <= mem_wr_req_in;
        r_offset <= iadder_in[1:0];
      end
      r_misaligned <= (r_state == ST_IDLE) && w_req && w_misaligned;
      r_bus_err    <= ((r_state == ST_DATA) && ahb_ready_in && ahb_resp_in) || w_timeout;
      r_load_valid <= (r_state == ST_DATA) && ahb_ready_in && !ahb_resp_in && !r_wr;
      if ((r_state == ST_DATA) && ahb_ready_in && !ahb_resp_in && !r_wr) begin
        r_load_data   <= ms_riscv32_mp_dmdata_in;
        r_load_offset <= r_offset;
      end
    end
  end

  assign load_data_out   = r_load_data;
  assign load_offset_out = r_load_offset;
  assign load_valid_out  = r_load_valid;
  assign misaligned_out  = r_misaligned;
  assign bus_err_out     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_dmem_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_msrv32_dmem_bus_ctrl: directed and random transactions against  |
// | a transaction-level reference model.              Revision: 1.0    |
// +--------------------------------------------------------------------+
module tb_msrv32_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] iadder = 32'd0, rs2 = 32'd0;
  logic        ready = 1'b0, resp = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [31:0] dmaddr, dmdata;
  logic [3:0]  dmmask;
  logic        dmwr;
  logic [1:0]  htrans;
  logic        stall;
  logic [31:0] ld_data;
  logic [1:0]  ld_off;
  logic        ld_valid, mis, berr;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_ld_data = 32'd0;
  logic [1:0]  m_ld_off  = 2'd0;

  msrv32_dmem_bus_ctrl dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .mem_rd_req_in               (rd_req),
    .mem_wr_req_in               (wr_req),
    .funct3_in                   (funct3),
    .iadder_in                   (iadder),
    .rs2_in                      (rs2),
    .ahb_ready_in                (ready),
    .ahb_resp_in                 (resp),
    .ms_riscv32_mp_dmdata_in     (rdata),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmdata_out    (dmdata),
    .ms_riscv32_mp_dmwr_mask_out (dmmask),
    .ms_riscv32_mp_dmwr_req_out  (dmwr),
    .ahb_htrans_out              (htrans),
    .stall_out                   (stall),
    .load_data_out               (ld_data),
    .load_offset_out             (ld_off),
    .load_valid_out              (ld_valid),
    .misaligned_out              (mis),
    .bus_err_out                 (berr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_mask(input logic is_wr, input logic [2:0] f3, input logic [31:0] a);
    int m;
    if (!is_wr) return 4'd0;
    m = ((1 << size_of(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic is_wr, input logic [2:0] f3, input logic [31:0] d);
    if (!is_wr) return 32'd0;
    case (size_of(f3))
      1:       return (d & 32'hFF) * 32'h01010101;
      2:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // one full access from the IDLE cycle through the completion pulse cycle
  task automatic do_txn(input logic is_wr, input logic both, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int aw,
                        input int dw, input logic r, input logic [31:0] rd_word);
    logic m;
    m = exp_mis(f3, a);
    wr_req = is_wr; rd_req = !is_wr || both; funct3 = f3; iadder = a; rs2 = d;
    ready = 1'b0; resp = 1'b0;
    #1;
    check("accept_stall", stall, !m);
    step();
    rd_req = 1'b0; wr_req = 1'b0; iadder = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 2));
    #1;
    check("prev_pulse_lv", ld_valid, 0);
    check("prev_pulse_err", berr, 0);
    if (m) begin
      check("mis_pulse", mis, 1);
      check("mis_htrans", htrans, 0);
      check("mis_stall", stall, 0);
      return;
    end
    check("addr_mis", mis, 0);
    check("addr_htrans", htrans, 2'b10);
    check("addr_dmaddr", dmaddr, a & 32'hFFFF_FFFC);
    check("addr_mask", dmmask, exp_mask(is_wr, f3, a));
    check("addr_wdata", dmdata, exp_wdata(is_wr, f3, d));
    check("addr_wr", dmwr, is_wr);
    check("addr_stall", stall, 1);
    for (int i = 0; i < aw; i++) begin
      step();
      check("addr_wait_htrans", htrans, 2'b10);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    #1;
    check("data_htrans", htrans, 0);
    check("data_stall", stall, 1);
    check("data_wdata", dmdata, exp_wdata(is_wr, f3, d));
    for (int i = 0; i < dw; i++) begin
      step();
      check("data_wait_stall", stall, 1);
    end
    ready = 1'b1; resp = r; rdata = rd_word;
    #1;
    check("ready_stall", stall, 0);
    step();
    ready = 1'b0; resp = 1'b0; rdata = $urandom;
    #1;
    if (!is_wr && !r) begin
      m_ld_data = rd_word;
      m_ld_off  = a[1:0];
    end
    check("done_lv", ld_valid, !is_wr && !r);
    check("done_err", berr, r);
    check("done_ldata", ld_data, m_ld_data);
    check("done_loff", ld_off, m_ld_off);
    check("done_htrans", htrans, 0);
  endtask

  initial begin
    logic [2:0] f3s [5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    step();
    step();
    check("rst_outs", {dmaddr, dmmask, dmwr, htrans, stall, ld_valid, mis, berr}, 0);
    check("rst_ldata", ld_data, 0);
    rst = 1'b0;
    step();
    check("idle_stall", stall, 0);

    do_txn(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    do_txn(1, 0, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 0);
    do_txn(1, 1, 3'b001, 32'h102, 32'h00001234, 1, 0, 0, 0);
    do_txn(0, 0, 3'b010, 32'h200, 32'h0, 0, 3, 0, 32'h12345678);
    do_txn(0, 0, 3'b001, 32'h201, 32'h0, 0, 0, 0, 0);
    do_txn(0, 0, 3'b010, 32'h202, 32'h0, 0, 0, 0, 0);
    do_txn(0, 0, 3'b010, 32'h204, 32'h0, 0, 1, 1, 32'hBADBAD00);
    do_txn(0, 0, 3'b101, 32'h306, 32'h0, 2, 2, 0, 32'hCAFEF00D);

    for (int n = 0; n < 40; n++) begin
      logic        w;
      logic [2:0]  f;
      logic [31:0] a;
      w = 1'($urandom);
      f = f3s[$urandom_range(0, 4)];
      if (w) f = {1'b0, f[1:0]};
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f)) - 1);
      do_txn(w, 1'($urandom), f, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), $urandom);
    end

    // asynchronous reset in the middle of a data phase
    rd_req = 1'b1; funct3 = 3'b010; iadder = 32'h200;
    step();
    rd_req = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_outs", {dmaddr, dmdata, dmmask, dmwr, htrans, stall, ld_valid, mis, berr}, 0);
    check("midrst_ldata", {ld_data, ld_off}, 0);
    m_ld_data = 32'd0; m_ld_off = 2'd0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", {htrans, stall, berr, ld_valid}, 0);

`ifdef MSRV32_DMEM_TIMEOUT_EN
    rd_req = 1'b1; funct3 = 3'b010; iadder = 32'h300;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_still_addr", htrans, 2'b10);
    step();
    check("to_err", berr, 1);
    check("to_stall", stall, 0);
    check("to_htrans", htrans, 0);
`endif

    do_txn(0, 0, 3'b000, 32'h401, 32'h0, 0, 0, 0, 32'h11223344);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
